// File: rtl/ripple_carry_adder_pkg.sv
// ============================================================================
// Module      : ripple_carry_adder_pkg
// Description : Shared constants for the registered ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ripple_carry_adder_pkg;

  // Default operand/sum width; legal widths are 1..32.
  localparam int RCA_DEFAULT_WIDTH = 4;

endpackage : ripple_carry_adder_pkg

`default_nettype wire

// File: rtl/ripple_carry_adder_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : One-bit combinational full adder. It holds no state and is
//               used as one stage of the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_prop;

  // The propagate term is shared by the sum and the carry equations.
  assign w_prop = a ^ b;
  assign sum    = w_prop ^ cin;
  assign cout   = (a & b) | (cin & w_prop);

endmodule : full_adder

`default_nettype wire

// File: rtl/ripple_carry_adder.sv
// ============================================================================
// Module      : ripple_carry_adder
// Description : WIDTH-bit unsigned adder built as a chain of one-bit full
//               adders, with the sum and carry-out registered. Latency is
//               one cycle. rst clears the outputs asynchronously.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // w_c[i] is the carry into stage i; w_c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign w_c[0] = cin;

  // Build the chain from one full adder per bit. Each stage takes its carry
  // from the stage below it, so the carry ripples from bit 0 to the MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .sum  (sum_d[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout_d = w_c[WIDTH];

  // Output register: it loads the chain result on every edge. Reset clears it
  // at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : ripple_carry_adder

`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
// ============================================================================
// Module      : tb_ripple_carry_adder
// Description : Self-checking bench for ripple_carry_adder (WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_carry_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition, cut to W+1 bits.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    int r;
    r = int'(x) + int'(y) + int'(ci);
    return r[W:0];
  endfunction

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {cout,sum}=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive operands after the falling edge, then sample #1 after the next rising edge.
  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    a = x; b = y; cin = ci;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 4'h0, b: 4'h0, cin: 1'b0, s: 4'h0, co: 1'b0};
    vecs[1] = '{a: 4'hF, b: 4'h0, cin: 1'b1, s: 4'h0, co: 1'b1};
    vecs[2] = '{a: 4'h7, b: 4'h8, cin: 1'b0, s: 4'hF, co: 1'b0};
    vecs[3] = '{a: 4'hF, b: 4'hF, cin: 1'b1, s: 4'hF, co: 1'b1};
    vecs[4] = '{a: 4'hF, b: 4'hF, cin: 1'b0, s: 4'hE, co: 1'b1};

    // Reset held from time zero with worst-case inputs present.
    rst = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;
    #2;
    chk("reset_initial", {cout, sum}, 5'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held_over_edges", {cout, sum}, 5'h00);

    // Release reset; the first edge must show the inputs sampled at that edge.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_after_release", {cout, sum}, 5'h1F);

    // Async reset between edges with no clock edge involved.
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_immediate", {cout, sum}, 5'h00);
    @(posedge clk);
    #1;
    chk("async_reset_held", {cout, sum}, 5'h00);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin);
      chk($sformatf("table[%0d]", i), {cout, sum}, {vecs[i].co, vecs[i].s});
    end

    // Inputs that change between edges must not reach the outputs.
    apply(4'h3, 4'h4, 1'b1);
    chk("hold_before", {cout, sum}, 5'h08);
    a = 4'hF; b = 4'hF; cin = 1'b1;
    #2;
    chk("hold_between_edges", {cout, sum}, 5'h08);
    @(posedge clk);
    #1;
    chk("hold_next_edge", {cout, sum}, 5'h1F);

    // Exhaustive sweep, with a reset pulse placed between edges partway through.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = i[8:0];
      @(negedge clk);
      a = idx[3:0]; b = idx[7:4]; cin = idx[8];
      if (i == 300) begin
        #1;
        rst = 1'b1;
        #1;
        chk("sweep_reset_pulse", {cout, sum}, 5'h00);
        rst = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("sweep[%0d]", i), {cout, sum}, ref_add(idx[3:0], idx[7:4], idx[8]));
    end

    // Randomized vectors checked against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rc = 1'($urandom_range(0, 1));
      apply(ra, rb, rc);
      chk($sformatf("random[%0d]", i), {cout, sum}, ref_add(ra, rb, rc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ripple_carry_adder

`default_nettype wire
